// File: rtl/square_plotter.sv
// Expands {x, y, colour} square requests into SQ_W x SQ_H single-pixel VGA writes,
// one per clock. Optional macro SQUARE_BORDER_EN draws a white outline on non-black squares.
module square_plotter #(
  parameter int SQ_W     = 4,
  parameter int SQ_H     = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_x,
  input  logic [6:0] in_y,
  input  logic [2:0] in_colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam logic [3:0] CX_LAST = 4'(SQ_W - 1);
  localparam logic [3:0] CY_LAST = 4'(SQ_H - 1);
  localparam logic [8:0] LIM_X   = 9'(SCREEN_W);
  localparam logic [7:0] LIM_Y   = 8'(SCREEN_H);

  state_t     state, state_nxt;
  logic [7:0] bx;
  logic [6:0] by;
  logic [2:0] col;
  logic [3:0] cx, cy, cx_nxt, cy_nxt;
  logic       accept;

  // Sums are one bit wider than the ports so off-screen pixels can be detected.
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       on_screen;
  logic [2:0] pix_col;

  assign accept    = (state == IDLE) && in_valid;
  assign sum_x     = {1'b0, bx} + {5'b0, cx};
  assign sum_y     = {1'b0, by} + {4'b0, cy};
  assign on_screen = (sum_x < LIM_X) && (sum_y < LIM_Y);

  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    case (state)
      IDLE: begin
        cx_nxt = 4'd0;
        cy_nxt = 4'd0;
        if (in_valid) state_nxt = DRAW;
      end
      DRAW: begin
        if (cx == CX_LAST) begin
          cx_nxt = 4'd0;
          if (cy == CY_LAST) begin
            cy_nxt    = 4'd0;
            state_nxt = DONE;
          end else begin
            cy_nxt = cy + 4'd1;
          end
        end else begin
          cx_nxt = cx + 4'd1;
        end
      end
      DONE: begin
        cx_nxt    = 4'd0;
        cy_nxt    = 4'd0;
        state_nxt = IDLE;
      end
      default: begin
        cx_nxt    = 4'd0;
        cy_nxt    = 4'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      bx    <= 8'd0;
      by    <= 7'd0;
      col   <= 3'd0;
      cx    <= 4'd0;
      cy    <= 4'd0;
    end else begin
      state <= state_nxt;
      cx    <= cx_nxt;
      cy    <= cy_nxt;
      if (accept) begin
        bx  <= in_x;
        by  <= in_y;
        col <= in_colour;
      end
    end
  end

`ifdef SQUARE_BORDER_EN
  logic is_edge;
  assign is_edge = (cx == 4'd0) || (cx == CX_LAST) || (cy == 4'd0) || (cy == CY_LAST);

  // Black stays black everywhere so erasing a square still clears its outline.
  always_comb begin
    pix_col = col;
    if (is_edge && (col != 3'b000)) pix_col = 3'b111;
  end
`else
  always_comb begin
    pix_col = col;
  end
`endif

  // All outputs decode registered state only; nothing flows from in_* to vga_*.
  assign in_ready   = (state == IDLE);
  assign done       = (state == DONE);
  assign vga_plot   = (state == DRAW) && on_screen;
  assign vga_x      = (state == DRAW) ? sum_x[7:0] : 8'd0;
  assign vga_y      = (state == DRAW) ? sum_y[6:0] : 7'd0;
  assign vga_colour = (state == DRAW) ? pix_col : 3'd0;

endmodule

// File: tb/tb_square_plotter.sv
// Randomized bench for square_plotter: a pixel-index reference model is compared on
// every falling edge, plus directed literal checks for the documented scenarios.
module tb_square_plotter;
  localparam int SQ_W = 4, SQ_H = 4, N = SQ_W * SQ_H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       done;

  int checks = 0;
  int failures = 0;

  square_plotter #(.SQ_W(SQ_W), .SQ_H(SQ_H), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pos = -1 idle, 0..N-1 pixel index in raster order, N = done cycle.
  int       pos = -1;
  int       cyc = 0;
  int       acc_cnt = 0;
  int       acc_cyc[$];
  int       mbx, mby, mcol;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pos = -1;
    end else begin
      cyc++;
      if (pos == -1) begin
        if (in_valid === 1'b1) begin
          mbx = int'(in_x); mby = int'(in_y); mcol = int'(in_colour);
          pos = 0;
          acc_cnt++;
          acc_cyc.push_back(cyc);
        end
      end else if (pos == N) begin
        pos = -1;
      end else begin
        pos++;
      end
    end
  end

  function automatic int exp_colour(input int p);
    int cx, cy;
    cx = p % SQ_W;
    cy = p / SQ_W;
`ifdef SQUARE_BORDER_EN
    if (mcol != 0 && (cx == 0 || cx == SQ_W - 1 || cy == 0 || cy == SQ_H - 1)) return 7;
`endif
    return mcol + 0 * (cx + cy);
  endfunction

  always @(negedge clk) begin
    int sx, sy;
    if (pos >= 0 && pos < N) begin
      sx = mbx + pos % SQ_W;
      sy = mby + pos / SQ_W;
      chk("m_ready", int'(in_ready), 0);
      chk("m_done", int'(done), 0);
      chk("m_plot", int'(vga_plot), (sx < 160 && sy < 120) ? 1 : 0);
      chk("m_x", int'(vga_x), sx % 256);
      chk("m_y", int'(vga_y), sy % 128);
      chk("m_colour", int'(vga_colour), exp_colour(pos));
    end else begin
      chk("m_ready", int'(in_ready), (pos == -1) ? 1 : 0);
      chk("m_done", int'(done), (pos == N) ? 1 : 0);
      chk("m_plot", int'(vga_plot), 0);
      chk("m_colour", int'(vga_colour), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and returns once it has been accepted (now in pixel 0's cycle).
  task automatic req(input int x, input int y, input int c);
    int start;
    start = acc_cnt;
    in_valid = 1'b1; in_x = 8'(x); in_y = 7'(y); in_colour = 3'(c);
    for (int i = 0; i < 100; i++) begin
      step();
      if (acc_cnt != start) break;
    end
    chk("accept_timeout", int'(acc_cnt != start), 1);
    in_valid = 1'b0;
  endtask

  // Observes one full square from pixel 0 and tallies its writes.
  task automatic observe(output int plots, output int whites, output int first_col_cnt,
                         input int c);
    plots = 0; whites = 0; first_col_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (vga_plot) plots++;
      if (vga_colour == 3'b111) whites++;
      if (int'(vga_colour) == c) first_col_cnt++;
      if (i < N - 1) step();
    end
    step();
    chk("sq_done", int'(done), 1);
  endtask

  initial begin
    int p, w, cc, a0;
    resetn = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
    #12;
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    @(posedge clk); #1 resetn = 1'b1;

    // Basic square: raster order starting at the top-left corner.
    req(1, 53, 3'b100);
    chk("t2_first_x", int'(vga_x), 1);
    chk("t2_first_y", int'(vga_y), 53);
    chk("t2_first_plot", int'(vga_plot), 1);
    step(); chk("t2_second_x", int'(vga_x), 2);
    repeat (3) step();
    chk("t2_wrap_x", int'(vga_x), 1);
    chk("t2_wrap_y", int'(vga_y), 54);
    repeat (11) step();
    chk("t2_last_x", int'(vga_x), 4);
    chk("t2_last_y", int'(vga_y), 56);
    step(); chk("t2_done", int'(done), 1);
    chk("t2_done_plot", int'(vga_plot), 0);
    step(); chk("t2_ready", int'(in_ready), 1);

    // Back-to-back: second request held during DRAW is taken only after DONE.
    a0 = acc_cnt;
    req(10, 10, 3'b010);
    in_valid = 1'b1; in_x = 8'd40; in_y = 7'd20; in_colour = 3'b011;
    for (int i = 0; i < 40 && acc_cnt == a0 + 1; i++) step();
    in_valid = 1'b0;
    chk("t3_accepts", acc_cnt - a0, 2);
    chk("t3_gap", acc_cyc[acc_cyc.size() - 1] - acc_cyc[acc_cyc.size() - 2], 18);
    chk("t3_first_x", int'(vga_x), 40);
    repeat (20) step();

    // Clipping at the bottom-right corner.
    req(158, 118, 3'b110);
    observe(p, w, cc, 6);
    chk("t4_plots", p, 4);

    // Border option.
    step();
    req(20, 30, 3'b001);
    observe(p, w, cc, 1);
`ifdef SQUARE_BORDER_EN
    chk("t6_blue_white", w, 12);
    chk("t6_blue_int", cc, 4);
`else
    chk("t6_blue_all", cc, 16);
`endif
    step();
    req(20, 30, 3'b000);
    observe(p, w, cc, 0);
    chk("t6_black", cc, 16);
    chk("t6_black_plots", p, 16);

    // Reset in the middle of a square.
    step();
    req(50, 50, 3'b101);
    repeat (6) step();
    #2 resetn = 1'b0;
    #1;
    chk("t5_plot", int'(vga_plot), 0);
    chk("t5_ready", int'(in_ready), 1);
    chk("t5_done", int'(done), 0);
    @(posedge clk); #1 resetn = 1'b1;
    p = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (vga_plot) p++;
    end
    chk("t5_residual", p, 0);

    // Random traffic, biased toward the screen edges to exercise clipping and wrap.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_x      = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom);
      in_y      = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom);
      in_colour = 3'($urandom);
      if (i == 1500) begin
        #2 resetn = 1'b0;
        #3 resetn = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    repeat (20) step();
    chk("rand_accepts", int'(acc_cnt > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
